bp_update_ctrl: RTL
===================

Name: bp_update_ctrl

Overview:
- Sequences all writes into the core's BTB/BHT branch predictor tables. It sits between the EX stage and the predictor's single write port.
- Buffers resolved branch/jump outcomes from EX in a small FIFO and drains them one per cycle onto the table update port.
- On a flush request (fence.i, context switch), it runs an invalidation sweep over every table index. During the sweep, EX updates are stalled behind it so that no stale entry survives.

Parameters:
- ENTRIES, 64, number of predictor table entries (power of 2).
- INDEX_BITS, 6, log2(ENTRIES).
- DEPTH, 4, update FIFO depth (power of 2, >=2).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- ex_valid  input  1  EX stage holds a valid resolved instruction this cycle.
- ex_is_branch  input  1  instruction is a conditional branch.
- ex_is_jump  input  1  instruction is a JAL.
- ex_pc  input  32  PC of the instruction.
- ex_taken  input  1  actual outcome.
- ex_target  input  32  actual target address.
- ex_ready  output  1  FIFO can accept a push this cycle (= !full).
- flush_req  input  1  single-cycle request to invalidate all entries.
- flush_busy  output  1  sweep in progress.
- flush_done  output  1  one-cycle pulse when a sweep completes.
- upd_valid  output  1  write one update to the tables.
- upd_index  output  INDEX_BITS  table index, = upd_pc[INDEX_BITS+1:2].
- upd_pc  output  32  tag value to write.
- upd_taken  output  1  counter direction (increment/decrement).
- upd_target  output  32  BTB target to write.
- inv_valid  output  1  clear the valid bit at inv_index and set its counter to 2'b01.
- inv_index  output  INDEX_BITS  index being invalidated.
- drop_cnt  output  16  saturating count of updates lost because the FIFO was full.

Behaviour:
- Clock and reset: clk, with asynchronous active-low reset rst_n. All outputs are registered except ex_ready.
- Reset values:
  - state = IDLE, FIFO empty, ex_ready = 1.
  - upd_valid = 0, inv_valid = 0, flush_busy = 0, flush_done = 0, drop_cnt = 0.
  - upd_*/inv_index = 0.
- Push condition: push = ex_valid & (ex_is_branch | ex_is_jump) & !full. The entry stores {pc, taken, target}. Non-branch ex_valid cycles are ignored.
- Drop counting: ex_valid & (branch|jump) & full increments drop_cnt, which saturates at 16'hFFFF. No push occurs.
- FIFO: circular, with read/write pointers of log2(DEPTH)+1 bits.
  - full = MSBs differ and the low bits are equal.
  - empty = pointers equal.
  - Pointers wrap modulo 2*DEPTH.
  - Simultaneous push and pop while full is not possible (push is blocked). Push and pop in the same cycle when neither full nor empty are both performed.
- States: IDLE and SWEEP.
- IDLE:
  - Each cycle, if the FIFO is non-empty, pop the head. On the next edge, drive upd_valid = 1 with the head's fields. Otherwise upd_valid = 0.
  - Latency from an accepted push at edge N (into an empty FIFO) to upd_valid high is one cycle: visible after edge N+1.
  - Throughput is 1 update per cycle.
- IDLE -> SWEEP on flush_req:
  - The FIFO is cleared, so updates queued before the flush are discarded as stale.
  - A push in the same cycle as flush_req is also discarded.
  - No pop occurs, and upd_valid = 0 from the next edge.
  - The sweep counter is set to 0 and flush_busy = 1.
- SWEEP:
  - Each cycle, drive inv_valid = 1 with inv_index = counter, then increment the counter.
  - upd_valid is held at 0, and the FIFO does not pop.
  - Pushes are accepted until full; overflow is counted in drop_cnt.
  - The sweep issues exactly ENTRIES invalidations, for indices 0..ENTRIES-1.
- SWEEP exit: after inv_index = ENTRIES-1 has been issued, the next edge:
  - sets inv_valid = 0, flush_busy = 0, flush_done = 1 (for one cycle);
  - returns state to IDLE.
  - Draining of entries pushed during the sweep resumes the cycle after the exit.
- flush_req during SWEEP restarts the sweep:
  - counter returns to 0 and the FIFO is cleared again;
  - no flush_done is produced for the aborted sweep.
- flush_req on the same cycle as the final invalidation also restarts; flush_done is not pulsed.
- Invariant: upd_valid and inv_valid are never high in the same cycle.
- Asynchronous reset mid-sweep: all state returns to reset values immediately. No flush_done is produced, and the sweep is not resumed.

Test Plan:
1. Reset, then push one branch (pc=0x100, taken=1, target=0x200) -> upd_valid high exactly one cycle later with upd_index=0x00, upd_pc=0x100, upd_target=0x200, upd_taken=1.
2. Hold the FIFO full (simulate by pushing 5 branches on consecutive cycles while in SWEEP) -> ex_ready low after 4 pushes, drop_cnt=1. After sweep exit, 4 upd_valid cycles in push order.
3. Pulse flush_req with 2 entries queued -> FIFO cleared, 64 consecutive inv_valid cycles with inv_index 0..63. Then flush_done pulses for one cycle, flush_busy falls, and no upd_valid appears for the discarded entries.
4. Pulse flush_req again at inv_index=30 -> next inv_index=0, total 64 more invalidations, only one flush_done.
5. Assert rst_n low at inv_index=10 -> inv_valid, flush_busy and drop_cnt drop to 0 asynchronously. After release, no further invalidations and no flush_done.
6. Push a non-branch (ex_valid=1, is_branch=0, is_jump=0) and a JAL (pc=0x40, target=0x80) -> only the JAL produces upd_valid, with upd_index=0x10.

Source files
------------

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl
// Sequences all writes into the BTB/BHT predictor tables through their single
// write port. Resolved branch/JAL outcomes from EX are buffered in a small
// FIFO and drained one per cycle as table updates. A flush request runs an
// invalidation sweep over every table index. Updates that were queued before
// the flush are discarded. New EX updates queue up behind the sweep.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ex_*_i              resolved instruction from EX (valid, kind, pc, outcome)
//   ex_ready_o          FIFO can accept a push this cycle (combinational, = !full)
//   flush_req_i         single-cycle request to invalidate all entries
//   flush_busy_o        sweep in progress
//   flush_done_o        one-cycle pulse when a sweep completes
//   upd_*_o             table update (index, tag pc, direction, target)
//   inv_valid_o/index_o invalidate one table index
//   drop_cnt_o          saturating count of updates lost to a full FIFO
//
// state | meaning
// IDLE  | drain FIFO head onto the update port, one entry per cycle
// SWEEP | issue invalidations 0..ENTRIES-1; FIFO accepts pushes but is not drained
module bp_update_ctrl #(
  parameter int ENTRIES    = 64,
  parameter int INDEX_BITS = 6,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid_i,
  input  logic                  ex_is_branch_i,
  input  logic                  ex_is_jump_i,
  input  logic [31:0]           ex_pc_i,
  input  logic                  ex_taken_i,
  input  logic [31:0]           ex_target_i,
  output logic                  ex_ready_o,
  input  logic                  flush_req_i,
  output logic                  flush_busy_o,
  output logic                  flush_done_o,
  output logic                  upd_valid_o,
  output logic [INDEX_BITS-1:0] upd_index_o,
  output logic [31:0]           upd_pc_o,
  output logic                  upd_taken_o,
  output logic [31:0]           upd_target_o,
  output logic                  inv_valid_o,
  output logic [INDEX_BITS-1:0] inv_index_o,
  output logic [15:0]           drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(ENTRIES - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                state_q, state_d;
  logic [INDEX_BITS-1:0] cnt_q, cnt_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  upd_valid_q, upd_valid_d;
  logic [INDEX_BITS-1:0] upd_index_q, upd_index_d;
  logic [31:0]           upd_pc_q, upd_pc_d;
  logic                  upd_taken_q, upd_taken_d;
  logic [31:0]           upd_target_q, upd_target_d;
  logic                  inv_valid_q, inv_valid_d;
  logic [INDEX_BITS-1:0] inv_index_q, inv_index_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;

  logic [31:0] pc_mem     [DEPTH];
  logic        taken_mem  [DEPTH];
  logic [31:0] target_mem [DEPTH];

  logic is_ctrl, full, empty, push, drop, mem_we;
  logic [31:0] head_pc;

  assign is_ctrl = ex_valid_i & (ex_is_branch_i | ex_is_jump_i);
  assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign push    = is_ctrl & ~full;
  assign drop    = is_ctrl & full;
  assign head_pc = pc_mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    upd_valid_d  = 1'b0;
    upd_index_d  = upd_index_q;
    upd_pc_d     = upd_pc_q;
    upd_taken_d  = upd_taken_q;
    upd_target_d = upd_target_q;
    inv_valid_d  = 1'b0;
    inv_index_d  = inv_index_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    mem_we       = 1'b0;
    drop_cnt_d   = drop_cnt_q;

    if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;

    if (flush_req_i) begin
      // Flush wins over everything: queued entries and a same-cycle push are
      // stale, and an in-progress sweep restarts without a done pulse.
      state_d  = SWEEP;
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      busy_d   = 1'b1;
    end else begin
      if (push) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            upd_valid_d  = 1'b1;
            upd_index_d  = head_pc[INDEX_BITS+1:2];
            upd_pc_d     = head_pc;
            upd_taken_d  = taken_mem[rd_ptr_q[AW-1:0]];
            upd_target_d = target_mem[rd_ptr_q[AW-1:0]];
          end
        end
        SWEEP: begin
          // The last index is on the outputs this cycle, so this edge ends the sweep.
          if (inv_valid_q && inv_index_q == LAST_IDX) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            inv_valid_d = 1'b1;
            inv_index_d = cnt_q;
            cnt_d       = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      pc_mem[wr_ptr_q[AW-1:0]]     <= ex_pc_i;
      taken_mem[wr_ptr_q[AW-1:0]]  <= ex_taken_i;
      target_mem[wr_ptr_q[AW-1:0]] <= ex_target_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      upd_valid_q  <= 1'b0;
      upd_index_q  <= '0;
      upd_pc_q     <= '0;
      upd_taken_q  <= 1'b0;
      upd_target_q <= '0;
      inv_valid_q  <= 1'b0;
      inv_index_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      upd_valid_q  <= upd_valid_d;
      upd_index_q  <= upd_index_d;
      upd_pc_q     <= upd_pc_d;
      upd_taken_q  <= upd_taken_d;
      upd_target_q <= upd_target_d;
      inv_valid_q  <= inv_valid_d;
      inv_index_q  <= inv_index_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign ex_ready_o   = ~full;
  assign flush_busy_o = busy_q;
  assign flush_done_o = done_q;
  assign upd_valid_o  = upd_valid_q;
  assign upd_index_o  = upd_index_q;
  assign upd_pc_o     = upd_pc_q;
  assign upd_taken_o  = upd_taken_q;
  assign upd_target_o = upd_target_q;
  assign inv_valid_o  = inv_valid_q;
  assign inv_index_o  = inv_index_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule
